// File: rtl/rs232_rx_if.sv
// rs232_rx_if: receive-side result bus of the UART receiver.
// The master drives the received byte, its strobes and Busy. The slave consumes them.
interface rs232_rx_if;
    logic [7:0] RX_Data;
    logic       RX_Valid;
    logic       Framing_Error;
    logic       Parity_Error;
    logic       Busy;

    modport master (
        output RX_Data, RX_Valid, Framing_Error, Parity_Error, Busy
    );

    modport slave (
        input  RX_Data, RX_Valid, Framing_Error, Parity_Error, Busy
    );
endinterface

// File: rtl/rs232_rx.sv
// rs232_rx: UART receiver that samples at mid-bit.
// Default frame is 8N1, LSB first, 868 USER_CLK cycles per bit.
// Defining RS232_RX_PARITY_EN turns the frame into 8E1 and adds a PARITY state.
// Reset is synchronous and active-high.
module rs232_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int HALF_BIT     = 434
) (
    input  logic         USER_CLK,
    input  logic         Reset,
    input  logic         FPGA_SERIAL1_RX,
    rs232_rx_if.master   rx
);

`ifdef RS232_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    localparam logic [9:0] BIT_END  = 10'(CLKS_PER_BIT - 1);
    localparam logic [9:0] HALF_END = 10'(HALF_BIT - 1);

    state_t      state;
    logic [9:0]  cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        rx_m, rx_s, rx_q;
`ifdef RS232_RX_PARITY_EN
    logic        par_err;
`endif

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    // All three flops reset high so that reset never looks like a start bit.
    always_ff @(posedge USER_CLK) begin
        if (Reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_q <= 1'b1;
        end else begin
            rx_m <= FPGA_SERIAL1_RX;
            rx_s <= rx_m;
            rx_q <= rx_s;
        end
    end

    // Frame FSM with registered strobes. Every state entry clears the counter.
    always_ff @(posedge USER_CLK) begin
        if (Reset) begin
            state            <= IDLE;
            cnt              <= '0;
            bit_idx          <= '0;
            shreg            <= '0;
            rx.RX_Data       <= '0;
            rx.RX_Valid      <= 1'b0;
            rx.Framing_Error <= 1'b0;
            rx.Busy          <= 1'b0;
`ifdef RS232_RX_PARITY_EN
            rx.Parity_Error  <= 1'b0;
            par_err          <= 1'b0;
`endif
        end else begin
            rx.RX_Valid      <= 1'b0;
            rx.Framing_Error <= 1'b0;
`ifdef RS232_RX_PARITY_EN
            rx.Parity_Error  <= 1'b0;
`endif
            cnt <= cnt + 10'd1;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    // Only a high-to-low transition starts a frame, so a held-low line (break) is ignored.
                    if (rx_q && !rx_s) begin
                        state   <= START;
                        rx.Busy <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == HALF_END) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            // The line is high again at mid-start-bit, so treat it as a glitch and drop it silently.
                            state   <= IDLE;
                            rx.Busy <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (cnt == BIT_END) begin
                        cnt     <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef RS232_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
`ifdef RS232_RX_PARITY_EN
                PARITY: begin
                    if (cnt == BIT_END) begin
                        cnt     <= '0;
                        // Even parity: the data bits XORed with the parity bit must give 0.
                        par_err <= ^shreg ^ rx_s;
                        state   <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (cnt == BIT_END) begin
                        // Leave at mid-stop-bit so that a start bit following immediately is still caught.
                        cnt     <= '0;
                        state   <= IDLE;
                        rx.Busy <= 1'b0;
                        if (!rx_s) begin
                            rx.Framing_Error <= 1'b1;
`ifdef RS232_RX_PARITY_EN
                        end else if (par_err) begin
                            rx.Parity_Error  <= 1'b1;
`endif
                        end else begin
                            rx.RX_Data  <= shreg;
                            rx.RX_Valid <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    rx.Busy <= 1'b0;
                end
            endcase
        end
    end

`ifndef RS232_RX_PARITY_EN
    assign rx.Parity_Error = 1'b0;
`endif

endmodule

// File: tb/tb_rs232_rx.sv
// tb_rs232_rx: scoreboard bench for rs232_rx.
// Each frame the stimulus sends pushes its expected outcome: the strobe kind,
// the RX_Data that should be visible, and the strobe cycle. A negedge monitor
// pops one entry per strobe and compares it.
module tb_rs232_rx;
    localparam int CPB = 868;
    localparam int HALF = 434;
`ifdef RS232_RX_PARITY_EN
    localparam int LAT = HALF + 10 * CPB;
`else
    localparam int LAT = HALF + 9 * CPB;
`endif

    localparam int K_VALID = 0;
    localparam int K_FRAME = 1;
    localparam int K_PAR   = 2;

    logic USER_CLK = 1'b0;
    logic Reset    = 1'b1;
    logic pin      = 1'b1;

    rs232_rx_if bus ();
    rs232_rx dut (.USER_CLK(USER_CLK), .Reset(Reset), .FPGA_SERIAL1_RX(pin), .rx(bus));

    always #5 USER_CLK = ~USER_CLK;

    int cyc = 0;
    always @(posedge USER_CLK) cyc <= cyc + 1;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         t;
    } exp_t;

    exp_t       q[$];
    int         n_chk = 0;
    int         n_fail = 0;
    int         n_strb = 0;
    logic [7:0] last_good = 8'h00;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge USER_CLK);
        #1;
    endtask

    // Reference model: the outcome depends only on the frame content. A low stop bit wins; otherwise a bad parity bit; otherwise the byte is accepted.
    task automatic send_frame(input logic [7:0] d, input bit stop_b, input bit bad_par, input int bl);
        exp_t e;
        e.t = cyc + LAT + 2;
        if (!stop_b) e.kind = K_FRAME;
`ifdef RS232_RX_PARITY_EN
        else if (bad_par) e.kind = K_PAR;
`endif
        else begin
            e.kind    = K_VALID;
            last_good = d;
        end
        e.data = last_good;
        q.push_back(e);
        pin = 1'b0;
        tick(bl);
        for (int i = 0; i < 8; i++) begin
            pin = d[i];
            tick(bl);
        end
`ifdef RS232_RX_PARITY_EN
        pin = (^d) ^ bad_par;
        tick(bl);
`endif
        pin = stop_b;
        tick(bl);
    endtask

    exp_t me;
    int   ns;
    int   kact;
    int   dt;

    // Monitor: every strobe must match the oldest expectation.
    always @(negedge USER_CLK) begin
        if (!Reset) begin
            ns = int'(bus.RX_Valid) + int'(bus.Framing_Error) + int'(bus.Parity_Error);
            if (ns != 0) begin
                n_strb++;
                chk("strobe_onehot", ns, 1);
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: got V=%0b FE=%0b PE=%0b, expected none (cycle %0d)",
                             bus.RX_Valid, bus.Framing_Error, bus.Parity_Error, cyc);
                end else begin
                    me   = q.pop_front();
                    kact = bus.RX_Valid ? K_VALID : (bus.Framing_Error ? K_FRAME : K_PAR);
                    chk("strobe_kind", kact, me.kind);
                    chk("rx_data", int'(bus.RX_Data), int'(me.data));
                    dt = cyc - me.t;
                    n_chk++;
                    if (dt < -2 || dt > 2) begin
                        n_fail++;
                        $display("FAIL latency: got strobe at cycle %0d, expected %0d +/- 2", cyc, me.t);
                    end
                end
            end
        end
    end

    int s0;
    int busy_cnt;
    logic [7:0] rd;
    int rbl;
    bit rstop, rpar;

    initial begin
        Reset = 1'b1;
        pin   = 1'b1;
        tick(5);
        chk("reset_rx_data", int'(bus.RX_Data), 0);
        chk("reset_valid", int'(bus.RX_Valid), 0);
        chk("reset_ferr", int'(bus.Framing_Error), 0);
        chk("reset_perr", int'(bus.Parity_Error), 0);
        chk("reset_busy", int'(bus.Busy), 0);
        Reset = 1'b0;

        // Line idles high after reset, so no strobe may appear.
        s0 = n_strb;
        tick(5000);
        chk("idle_no_strobe", n_strb, s0);

        // A single good frame, nominal baud rate.
        s0 = n_strb;
        send_frame(8'hA5, 1'b1, 1'b0, CPB);
        tick(200);
        chk("a5_one_strobe", n_strb, s0 + 1);
        chk("a5_busy_after", int'(bus.Busy), 0);

        // A short low glitch: Busy should stay high for exactly the half-bit window and no strobe should fire.
        s0 = n_strb;
        busy_cnt = 0;
        pin = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if (i == 200) pin = 1'b1;
            tick(1);
            if (bus.Busy) busy_cnt++;
        end
        chk("glitch_busy_cycles", busy_cnt, HALF);
        chk("glitch_no_strobe", n_strb, s0);

        // Bad stop bit, then a held break: exactly one framing strobe and RX_Data keeps A5.
        s0 = n_strb;
        send_frame(8'h3C, 1'b0, 1'b0, CPB);
        tick(5000);
        pin = 1'b1;
        tick(500);
        chk("break_one_strobe", n_strb, s0 + 1);
        chk("break_rx_data", int'(bus.RX_Data), 8'hA5);

        // Back-to-back frames with no idle gap.
        send_frame(8'h00, 1'b1, 1'b0, CPB);
        send_frame(8'hFF, 1'b1, 1'b0, CPB);
        tick(100);

        // Reset in the middle of 0x5A: the partial byte must never appear.
        pin = 1'b0;
        tick(CPB);
        rd = 8'h5A;
        for (int i = 0; i < 4; i++) begin
            pin = rd[i];
            tick(CPB);
        end
        Reset = 1'b1;
        pin   = 1'b1;
        tick(5);
        Reset     = 1'b0;
        last_good = 8'h00;
        chk("midreset_rx_data", int'(bus.RX_Data), 0);
        chk("midreset_busy", int'(bus.Busy), 0);
        tick(50);
        s0 = n_strb;
        send_frame(8'hC3, 1'b1, 1'b0, CPB);
        tick(200);
        chk("c3_one_strobe", n_strb, s0 + 1);

        // Random frames: random data, a baud skew of +/-2%, occasional bad stop or parity, and a random gap.
        for (int f = 0; f < 2; f++) begin
            rd    = 8'($urandom);
            rbl   = CPB - 17 + int'($urandom_range(0, 34));
            rstop = ($urandom_range(0, 3) != 0);
            rpar  = ($urandom_range(0, 3) == 0);
            send_frame(rd, rstop, rpar, rbl);
            pin = 1'b1;
            tick(int'($urandom_range(10, 300)));
        end

`ifdef RS232_RX_PARITY_EN
        s0 = n_strb;
        send_frame(8'hC3, 1'b1, 1'b1, CPB);
        tick(200);
        chk("parity_one_strobe", n_strb, s0 + 1);
`endif

        tick(1000);
        chk("scoreboard_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Watchdog so that a stuck run still ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout at cycle %0d, expected end of test", cyc);
        $fatal(1, "watchdog");
    end
endmodule
